write_ptr_handler: RTL

Write-domain pointer and flag generator for the async FIFO. It sits directly upstream of the read-side pointer handler and owns the write binary pointer, which addresses the memory, and the write Gray pointer, which crosses to the read domain. It computes full, almost_full, fill level and an overflow flag from the read Gray pointer after synchronisation into the write domain.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/gray2bin_conv.sv | 14 +
 rtl/write_ptr_handler.sv | 91 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width and Gray/binary helpers
// used by both the write-side and read-side pointer handlers.
package fifo_pkg;

  localparam int PTR_WIDTH_DEFAULT = 6;
  localparam int GRAY_FN_W         = 32;

  // Operands are zero-extended into GRAY_FN_W bits, which leaves any narrower
  // pointer's conversion unchanged in its low bits.
  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gray);
    logic [GRAY_FN_W-1:0] bin;
    bin[GRAY_FN_W-1] = gray[GRAY_FN_W-1];
    for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin_conv #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/write_ptr_handler.sv
// Write-domain pointer and flag generator for the async FIFO.
// Optional sticky overflow flag and its assertion: define WPTR_OVERFLOW_FLAG_EN.
module write_ptr_handler
  import fifo_pkg::*;
#(
  parameter int ptr_width = PTR_WIDTH_DEFAULT,
  parameter int AF_THRESH = 28
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [ptr_width-1:0] g_rptr_sync,
  output logic [ptr_width-1:0] b_wptr,
  output logic [ptr_width-1:0] g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [ptr_width-1:0] wlevel,
  output logic                 overflow
);

  // Handshake: w_en acts as valid and ~full as ready; a write is taken only in
  // a cycle where both are high, otherwise the request is dropped, not held.

  localparam logic [ptr_width-1:0] AF_THRESH_W = ptr_width'(AF_THRESH);

  logic                 push;
  logic [ptr_width-1:0] b_wptr_next;
  logic [ptr_width-1:0] g_wptr_next;
  logic [ptr_width-1:0] g_full_match;
  logic [ptr_width-1:0] rbin;
  logic [ptr_width-1:0] wlevel_next;
  logic                 full_next;
  logic                 almost_full_next;

  assign push        = w_en & ~full;
  assign b_wptr_next = b_wptr + {{(ptr_width-1){1'b0}}, push};
  assign g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that is the top two bits inverted, the rest equal.
  assign g_full_match = {~g_rptr_sync[ptr_width-1:ptr_width-2], g_rptr_sync[ptr_width-3:0]};
  assign full_next    = (g_wptr_next == g_full_match);

  gray2bin_conv #(
    .W(ptr_width)
  ) u_rptr_conv (
    .gray(g_rptr_sync),
    .bin (rbin)
  );

  assign wlevel_next      = b_wptr_next - rbin;
  assign almost_full_next = (wlevel_next >= AF_THRESH_W);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wlevel      <= wlevel_next;
    end
  end

`ifdef WPTR_OVERFLOW_FLAG_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end
  end

  a_no_write_when_full : assert property (
    @(posedge wclk) disable iff (!wrst_n) !(w_en && full)
  ) else $error("write attempted while full");
`else
  assign overflow = 1'b0;
`endif

  // A held-off write must not move the pointer that crosses domains.
  a_full_holds_gptr : assert property (
    @(posedge wclk) disable iff (!wrst_n) (full && w_en) |=> $stable(g_wptr)
  );

endmodule
